gs232c_ras: RTL
===============

// Module: gs232c_ras
// PURPOSE
// Return-address stack for the fetch pipeline, directly downstream of the instruction judge stage.
// Consumes the judge's per-packet link/return decisions: pr_link pushes pr_link_pc, pr_jrra pops.
// Drives ra back to the judge combinationally for return-target prediction.
// Snapshots {ptr,cnt,top} per packet and restores them on backend repair or flush.
// PARAMETERS
// DEPTH  8   number of entries; power of 2, >=2; PW = log2(DEPTH)
// AW     30  entry width (word address, pc[31:2])
// PORTS
// clock         in   1      single clock, rising edge
// resetn        in   1      one clock; reset is asynchronous and active-low
// pr_valid      in   1      judge packet valid
// pr_accept     in   1      downstream accepts packet this cycle; update only on pr_valid&&pr_accept
// pr_link       in   1      packet's taken op writes link -> push
// pr_link_pc    in   AW     return address to push
// pr_jrra       in   1      packet's taken op is jr ra -> pop
// ra            out  AW     stack[ptr]; combinational from state
// ra_valid      out  1      cnt!=0
// snap_ptr      out  PW     ptr before this packet's update (travels with packet)
// snap_cnt      out  PW+1   cnt before update
// snap_top      out  AW     stack[ptr] before update
// repair_valid  in   1      backend branch resolution redirect
// repair_ptr    in   PW     snapshot ptr of the mispredicted packet
// repair_cnt    in   PW+1   snapshot cnt
// repair_top    in   AW     snapshot top entry
// repair_link   in   1      resolved op is a link op
// repair_link_pc in  AW     correct link address
// repair_jrra   in   1      resolved op is jr ra
// flush         in   1      exception/ertn: empty the stack
// perf_push_cnt out  32     accepted pushes; perf_pop_cnt out 32; perf_ovf_cnt out 32
// BEHAVIOUR
// - Reset (resetn=0, async): ptr=0, cnt=0, all entries 0, perf counters 0 -> ra=0, ra_valid=0, snap_*=0.
// - State: stack[DEPTH], ptr (points at current top), cnt (0..DEPTH). All updates at posedge; visible next cycle.
// - Op encoding from (link,jrra) with a source ptr P, cnt C, data D:
//   push (1,0): ptr=P+1 mod DEPTH; stack[P+1]=D; cnt=min(C+1,DEPTH); if C==DEPTH overwrite oldest, perf_ovf+1.
//   pop (0,1):  ptr=P-1 mod DEPTH; cnt=max(C-1,0); underflow (C==0) still moves ptr, ra_valid stays 0.
//   both(1,1):  stack[P]=D; ptr, cnt unchanged (pop-then-push).
//   none(0,0):  no change.
// - Priority per cycle: flush > repair_valid > predicted update; lower ones dropped that cycle.
// - flush: ptr=0, cnt=0; entries kept (not reset).
// - repair: stack[repair_ptr]=repair_top first, then apply op (repair_link,repair_jrra) from P=repair_ptr,
//   C=repair_cnt, D=repair_link_pc; when op is push, the push write to repair_ptr+1 wins; both-op writes
//   repair_link_pc to repair_ptr (overrides repair_top).
// - predicted: on pr_valid&&pr_accept apply op (pr_link,pr_jrra) from current ptr/cnt, D=pr_link_pc.
// - snap_* are combinational copies of current ptr/cnt/stack[ptr]; valid whenever pr_valid.
// - Perf counters count only predicted (not repair) pushes/pops; wrap at 2^32.
// - No stall on pr_valid&&!pr_accept: state holds, ra unchanged.
// TESTING
// 1. Reset, then 3 pushes 0x100,0x200,0x300 -> ra=0x300, cnt=3; 3 pops -> ra goes 0x200,0x100, then ra_valid=0.
// 2. DEPTH+2 pushes 1..10 (DEPTH=8) -> cnt=8, perf_ovf=2; 8 pops return 10..3; 9th pop ra_valid=0.
// 3. ra=0x40; packet with link&&jrra, pc 0x55 -> ra=0x55, cnt unchanged, ptr unchanged.
// 4. Capture snap (ptr=2,cnt=2,top=0x20); wrong-path pop+push 0x99; repair with snap, repair_link=1, pc 0x30 -> ptr=3, cnt=3, ra=0x30, stack[2]=0x20.
// 5. Same cycle flush, repair_valid and pr push -> ptr=0, cnt=0, no push counted.
// 6. Assert resetn low mid-stream with cnt=5 -> ra=0, ra_valid=0 immediately (before next edge).

Source files
------------

// File: rtl/gs232c_ras.sv
// Return-address stack for the fetch pipeline: predicted push/pop from the judge stage,
// per-packet {ptr,cnt,top} snapshots, and snapshot-based repair/flush from the backend.
module gs232c_ras #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 30,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          pr_valid,
  input  logic          pr_accept,
  input  logic          pr_link,
  input  logic [AW-1:0] pr_link_pc,
  input  logic          pr_jrra,
  output logic [AW-1:0] ra,
  output logic          ra_valid,
  output logic [PW-1:0] snap_ptr,
  output logic [PW:0]   snap_cnt,
  output logic [AW-1:0] snap_top,
  input  logic          repair_valid,
  input  logic [PW-1:0] repair_ptr,
  input  logic [PW:0]   repair_cnt,
  input  logic [AW-1:0] repair_top,
  input  logic          repair_link,
  input  logic [AW-1:0] repair_link_pc,
  input  logic          repair_jrra,
  input  logic          flush,
  output logic [31:0]   perf_push_cnt,
  output logic [31:0]   perf_pop_cnt,
  output logic [31:0]   perf_ovf_cnt
);

  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] stack [DEPTH];
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;

  // Operation source selection and next-state
  logic [PW-1:0] src_ptr, nxt_ptr, pre_wa, op_wa;
  logic [CW-1:0] src_cnt, nxt_cnt;
  logic [AW-1:0] src_d, pre_d;
  logic          op_link, op_jrra, pre_we, op_we, pred, is_push, is_pop, is_ovf;

  always_comb begin
    src_ptr = ptr;
    src_cnt = cnt;
    src_d   = pr_link_pc;
    op_link = 1'b0;
    op_jrra = 1'b0;
    pre_we  = 1'b0;
    pre_wa  = repair_ptr;
    pre_d   = repair_top;
    pred    = 1'b0;
    if (repair_valid) begin
      src_ptr = repair_ptr;
      src_cnt = repair_cnt;
      src_d   = repair_link_pc;
      op_link = repair_link;
      op_jrra = repair_jrra;
      pre_we  = 1'b1;
    end else if (pr_valid && pr_accept) begin
      op_link = pr_link;
      op_jrra = pr_jrra;
      pred    = 1'b1;
    end

    nxt_ptr = src_ptr;
    nxt_cnt = src_cnt;
    op_we   = 1'b0;
    op_wa   = src_ptr;
    is_push = 1'b0;
    is_pop  = 1'b0;
    is_ovf  = 1'b0;
    if (op_link && !op_jrra) begin
      is_push = 1'b1;
      nxt_ptr = src_ptr + PW'(1);
      op_we   = 1'b1;
      op_wa   = src_ptr + PW'(1);
      is_ovf  = (src_cnt == CW'(DEPTH));
      nxt_cnt = is_ovf ? src_cnt : src_cnt + CW'(1);
    end else if (!op_link && op_jrra) begin
      is_pop  = 1'b1;
      nxt_ptr = src_ptr - PW'(1);
      nxt_cnt = (src_cnt == CW'(0)) ? CW'(0) : src_cnt - CW'(1);
    end else if (op_link && op_jrra) begin
      op_we   = 1'b1;
    end

    // Flush overrides everything; entries are deliberately left intact
    if (flush) begin
      nxt_ptr = '0;
      nxt_cnt = '0;
      op_we   = 1'b0;
      pre_we  = 1'b0;
      pred    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
      cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      ptr <= nxt_ptr;
      cnt <= nxt_cnt;
      // Op write is issued last so it overrides the repaired top on the same entry
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (pre_we && pre_wa == PW'(i)) stack[i] <= pre_d;
        if (op_we && op_wa == PW'(i)) stack[i] <= src_d;
      end
    end
  end

  // Performance counters track predicted-path activity only
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      perf_push_cnt <= '0;
      perf_pop_cnt  <= '0;
      perf_ovf_cnt  <= '0;
    end else if (pred) begin
      if (is_push) perf_push_cnt <= perf_push_cnt + 32'd1;
      if (is_pop)  perf_pop_cnt  <= perf_pop_cnt + 32'd1;
      if (is_ovf)  perf_ovf_cnt  <= perf_ovf_cnt + 32'd1;
    end
  end

  assign ra       = stack[ptr];
  assign ra_valid = (cnt != CW'(0));
  assign snap_ptr = ptr;
  assign snap_cnt = cnt;
  assign snap_top = stack[ptr];

endmodule
